if_fetch_stage: RTL and testbench

Instruction-fetch stage of the 3PA pipeline: owns the program counter and drives the instruction-memory request handshake. Holds a one-entry skid buffer so that an instruction returned during a decode stall is not lost. Registers the fetched instruction, its PC, a valid bit and an instruction count into the IF/ID pipeline register, which feeds the decode stage. Branch/jump redirects and pipeline flushes arrive from downstream hazard/branch logic.

---
 rtl/if_fetch_stage.sv | 199 +++++++++++++++++++
 tb/tb_if_fetch_stage.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage. Owns the program counter, drives the
// instruction-memory request, and loads the IF/ID pipeline register that
// feeds decode. A one-entry skid buffer catches an instruction that is
// acknowledged while decode is stalled.
//
// Ports
//   Clk, reset           single clock, synchronous active-high reset
//   stall                hold IF/ID contents and PC
//   flush                invalidate the IF/ID entry at the next edge
//   redirect/redirect_pc next fetch address (bits [1:0] forced to 0)
//   imem_req/imem_addr   fetch request and address
//   imem_ready/imem_rdata acknowledge and returned instruction
//   oIR/oPC/oValid/oIC   IF/ID register outputs
//
// Handshake: a fetch completes in a cycle where imem_req=1 and imem_ready=1;
// imem_rdata is valid in that same cycle. imem_addr is held while imem_req=1
// and the fetch is not yet acknowledged. Dropping imem_req aborts a fetch.
//
// Build option: define IF_ICOUNT_EN to implement the oIC instruction
// counter; otherwise oIC is tied to 0 and no counter flops exist.
// ---------------------------------------------------------------------------
module if_fetch_stage #(
  parameter int                  PC_WIDTH   = 32,
  parameter int                  INST_WIDTH = 32,
  parameter int                  IC_WIDTH   = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  Clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  redirect,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_ready,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic [INST_WIDTH-1:0] oIR,
  output logic [PC_WIDTH-1:0]   oPC,
  output logic                  oValid,
  output logic [IC_WIDTH-1:0]   oIC
);

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [PC_WIDTH-1:0]   drain_addr_q, drain_addr_d;
  logic [INST_WIDTH-1:0] skid_ir_q, skid_ir_d;
  logic [PC_WIDTH-1:0]   skid_pc_q, skid_pc_d;
  logic [INST_WIDTH-1:0] ir_q, ir_d;
  logic [PC_WIDTH-1:0]   opc_q, opc_d;
  logic                  valid_q, valid_d;

  // Instruction handed to IF/ID this cycle (from memory or the skid buffer).
  logic                  deliver;
  logic [INST_WIDTH-1:0] deliver_ir;
  logic [PC_WIDTH-1:0]   deliver_pc;
  logic [PC_WIDTH-1:0]   redirect_tgt;

  assign redirect_tgt = redirect_pc & ~PC_WIDTH'(3);

  // Fetch FSM: next state, PC, skid buffer and memory request.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    skid_ir_d    = skid_ir_q;
    skid_pc_d    = skid_pc_q;
    deliver      = 1'b0;
    deliver_ir   = '0;
    deliver_pc   = '0;
    imem_req     = 1'b0;
    // While draining, the abandoned request must keep its original address.
    imem_addr    = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;

    case (state_q)
      ST_RST: begin
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        imem_req = 1'b1;
        if (redirect) begin
          pc_d = redirect_tgt;
          if (!imem_ready) begin
            // Request is already visible to memory; finish it and discard.
            drain_addr_d = pc_q;
            state_d      = ST_DRAIN;
          end
        end else if (imem_ready) begin
          pc_d = pc_q + PC_WIDTH'(4);
          if (stall) begin
            skid_ir_d = imem_rdata;
            skid_pc_d = pc_q;
            state_d   = ST_HOLD;
          end else begin
            deliver    = 1'b1;
            deliver_ir = imem_rdata;
            deliver_pc = pc_q;
          end
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          pc_d    = redirect_tgt;
          state_d = ST_FETCH;
        end else if (!stall) begin
          deliver    = 1'b1;
          deliver_ir = skid_ir_q;
          deliver_pc = skid_pc_q;
          state_d    = ST_FETCH;
        end
      end

      ST_DRAIN: begin
        imem_req = 1'b1;
        if (redirect) pc_d = redirect_tgt;
        if (imem_ready) state_d = ST_FETCH;
      end

      default: begin
        state_d = ST_RST;
      end
    endcase
  end

  // IF/ID register: flush beats stall beats load. An un-stalled cycle with
  // nothing delivered loads a bubble; oIR/oPC keep their old contents.
  always_comb begin
    ir_d    = ir_q;
    opc_d   = opc_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      valid_d = deliver;
      if (deliver) begin
        ir_d  = deliver_ir;
        opc_d = deliver_pc;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q      <= ST_RST;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      skid_ir_q    <= '0;
      skid_pc_q    <= '0;
      ir_q         <= '0;
      opc_q        <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      skid_ir_q    <= skid_ir_d;
      skid_pc_q    <= skid_pc_d;
      ir_q         <= ir_d;
      opc_q        <= opc_d;
      valid_q      <= valid_d;
    end
  end

  assign oIR    = ir_q;
  assign oPC    = opc_q;
  assign oValid = valid_q;

`ifdef IF_ICOUNT_EN
  logic [IC_WIDTH-1:0] ic_q, ic_d;

  // Counts valid IF/ID loads only; wraps naturally.
  always_comb begin
    ic_d = ic_q;
    if (!flush && !stall && deliver) ic_d = ic_q + IC_WIDTH'(1);
  end

  always_ff @(posedge Clk) begin
    if (reset) ic_q <= '0;
    else       ic_q <= ic_d;
  end

  assign oIC = ic_q;
`else
  assign oIC = '0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
//
// Drives if_fetch_stage cycle by cycle. A transaction-level reference model
// (next-fetch address, a skid queue, a pending-drain address) predicts the
// memory request and the IF/ID outputs after every edge; predictions are
// queued and compared one cycle at a time. Directed scenarios come first,
// followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

  localparam int PCW = 32;
  localparam int IW  = 32;
  localparam int ICW = 8;
  localparam logic [PCW-1:0] RST_PC = 32'h0000_0000;
  localparam int EXP_W = 1 + PCW + 1 + PCW + IW + ICW;

  // ---------------- clock / reset ----------------
  logic           Clk;
  logic           reset;
  logic           stall;
  logic           flush;
  logic           redirect;
  logic [PCW-1:0] redirect_pc;
  logic           imem_req;
  logic [PCW-1:0] imem_addr;
  logic           imem_ready;
  logic [IW-1:0]  imem_rdata;
  logic [IW-1:0]  oIR;
  logic [PCW-1:0] oPC;
  logic           oValid;
  logic [ICW-1:0] oIC;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  if_fetch_stage #(
    .PC_WIDTH  (PCW),
    .INST_WIDTH(IW),
    .IC_WIDTH  (ICW),
    .RESET_PC  (RST_PC)
  ) dut (
    .Clk        (Clk),
    .reset      (reset),
    .stall      (stall),
    .flush      (flush),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .oIR        (oIR),
    .oPC        (oPC),
    .oValid     (oValid),
    .oIC        (oIC)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [EXP_W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [IW-1:0] mem_word(input logic [PCW-1:0] a);
    return 32'h1111_0000 + a;
  endfunction

  // ---------------- reference model ----------------
  bit             m_started;   // a request has been issued since reset
  bit             m_draining;  // an abandoned request is still outstanding
  logic [PCW-1:0] m_drain_addr;
  logic [PCW-1:0] m_pc;        // next fetch address
  logic [63:0]    skid_q[$];   // {pc, ir} caught during a stall
  logic           m_valid;
  logic [PCW-1:0] m_opc;
  logic [IW-1:0]  m_oir;
  logic [ICW-1:0] m_ic;

  task automatic model_step(input logic rst, st, fl, rd,
                            input logic [PCW-1:0] rpc, input logic rdy);
    logic           got;
    logic [PCW-1:0] gpc;
    logic [IW-1:0]  gir;
    logic [PCW-1:0] tgt;
    logic [ICW-1:0] exp_ic;
    got = 1'b0;
    gpc = '0;
    gir = '0;
    tgt = rpc & 32'hFFFF_FFFC;
    if (rst) begin
      m_started    = 0;
      m_draining   = 0;
      m_drain_addr = RST_PC;
      m_pc         = RST_PC;
      skid_q.delete();
      m_valid = 0;
      m_opc   = '0;
      m_oir   = '0;
      m_ic    = '0;
    end else begin
      if (!m_started) begin
        m_started = 1;
      end else if (skid_q.size() != 0) begin
        if (rd) begin
          skid_q.delete();
          m_pc = tgt;
        end else if (!st) begin
          {gpc, gir} = skid_q.pop_front();
          got = 1'b1;
        end
      end else if (m_draining) begin
        if (rd) m_pc = tgt;
        if (rdy) m_draining = 0;
      end else begin
        if (rd) begin
          if (!rdy) begin
            m_draining   = 1;
            m_drain_addr = m_pc;
          end
          m_pc = tgt;
        end else if (rdy) begin
          if (st) skid_q.push_back({m_pc, mem_word(m_pc)});
          else begin
            got = 1'b1;
            gpc = m_pc;
            gir = mem_word(m_pc);
          end
          m_pc = m_pc + 32'd4;
        end
      end
      if (fl) m_valid = 1'b0;
      else if (!st) begin
        m_valid = got;
        if (got) begin
          m_opc = gpc;
          m_oir = gir;
          m_ic  = m_ic + 8'd1;
        end
      end
    end
`ifdef IF_ICOUNT_EN
    exp_ic = m_ic;
`else
    exp_ic = '0;
`endif
    exp_q.push_back({m_started && (skid_q.size() == 0),
                     m_draining ? m_drain_addr : m_pc,
                     m_valid, m_opc, m_oir, exp_ic});
  endtask

  task automatic compare_outputs(input logic rst);
    logic [EXP_W-1:0] e;
    if (exp_q.size() == 0) begin
      check_eq("exp_q_empty", 64'd1, 64'd0);
      return;
    end
    e = exp_q.pop_front();
    check_eq("imem_req",  {63'd0, imem_req}, {63'd0, e[EXP_W-1]});
    check_eq("imem_addr", {32'd0, imem_addr}, {32'd0, e[EXP_W-2 -: PCW]});
    check_eq("oValid",    {63'd0, oValid}, {63'd0, e[IW+PCW+ICW]});
    // oPC/oIR are don't-care while the entry is invalid, except at reset.
    if (e[IW+PCW+ICW] || rst) begin
      check_eq("oPC", {32'd0, oPC}, {32'd0, e[IW+ICW +: PCW]});
      check_eq("oIR", {32'd0, oIR}, {32'd0, e[ICW +: IW]});
    end
    check_eq("oIC", {56'd0, oIC}, {56'd0, e[ICW-1:0]});
  endtask

  // ---------------- driver ----------------
  // Called just after an active edge: applies inputs for the coming cycle,
  // lets the edge happen, advances the model and checks 1 time unit later.
  task automatic step(input logic rst, st, fl, rd,
                      input logic [PCW-1:0] rpc, input logic rdy);
    reset       = rst;
    stall       = st;
    flush       = fl;
    redirect    = rd;
    redirect_pc = rpc;
    imem_ready  = rdy;
    imem_rdata  = mem_word(imem_addr);
    @(posedge Clk);
    model_step(rst, st, fl, rd, rpc, rdy);
    #1;
    compare_outputs(rst);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [ICW-1:0] ic_exp;
    reset = 1'b1; stall = 0; flush = 0; redirect = 0;
    redirect_pc = '0; imem_ready = 0; imem_rdata = '0;

    // Reset, then zero-wait memory.
    repeat (3) step(1, 0, 0, 0, 0, 0);
    check_eq("rst_req", {63'd0, imem_req}, 64'd0);
    step(0, 0, 0, 0, 0, 0);
    check_eq("first_req", {63'd0, imem_req}, 64'd1);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0, 0, 1);
      check_eq("zw_pc", {32'd0, oPC}, 64'(4 * k));
`ifdef IF_ICOUNT_EN
      ic_exp = ICW'(k + 1);
`else
      ic_exp = '0;
`endif
      check_eq("zw_ic", {56'd0, oIC}, {56'd0, ic_exp});
    end

    // Two wait states on address 16.
    step(0, 0, 0, 0, 0, 0);
    check_eq("wait_addr", {32'd0, imem_addr}, 64'h10);
    step(0, 0, 0, 0, 0, 0);
    check_eq("wait_valid", {63'd0, oValid}, 64'd0);
    step(0, 0, 0, 0, 0, 1);
    check_eq("wait_pc", {32'd0, oPC}, 64'h10);

    // Stall for 3 cycles while address 20 is acknowledged.
    step(0, 1, 0, 0, 0, 1);
    check_eq("hold_req", {63'd0, imem_req}, 64'd0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    check_eq("hold_pc", {32'd0, oPC}, 64'h10);
    step(0, 0, 0, 0, 0, 0);
    check_eq("skid_pc", {32'd0, oPC}, 64'h14);
    step(0, 0, 0, 0, 0, 1);
    check_eq("after_skid_pc", {32'd0, oPC}, 64'h18);

    // Redirect while address 28 is outstanding.
    step(0, 0, 0, 1, 32'h0000_0203, 0);
    check_eq("drain_addr", {32'd0, imem_addr}, 64'h1C);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    check_eq("redir_addr", {32'd0, imem_addr}, 64'h200);
    step(0, 0, 0, 0, 0, 1);
    check_eq("redir_pc", {32'd0, oPC}, 64'h200);

    // Flush together with stall, then reset during a wait.
    step(0, 1, 1, 0, 0, 0);
    check_eq("flush_valid", {63'd0, oValid}, 64'd0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check_eq("midrst_req", {63'd0, imem_req}, 64'd0);
    check_eq("midrst_addr", {32'd0, imem_addr}, {32'd0, RST_PC});
    step(0, 0, 0, 0, 0, 0);
    check_eq("midrst_fetch", {32'd0, imem_addr}, {32'd0, RST_PC});

    // PC wrap at the top of the address space.
    step(0, 0, 0, 1, 32'hFFFF_FFFF, 1);
    check_eq("wrap_addr_hi", {32'd0, imem_addr}, 64'hFFFF_FFFC);
    step(0, 0, 0, 0, 0, 1);
    check_eq("wrap_addr_lo", {32'd0, imem_addr}, 64'h0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      logic [PCW-1:0] rpc;
      rpc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8 : $urandom();
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 11) == 0,
           rpc,
           $urandom_range(0, 2) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
